// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register map, bit positions and FSM states for the UART transmitter
package uart_tx_dev_pkg;
    localparam int DEV_ADDR_WD = 8;
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_CTRL   = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;
    localparam logic [1:0] UART_REG_STATUS = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int ST_OVF_CLR = 3;
    typedef enum logic [1:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP} utx_state_e;
endpackage

// File: rtl/uart_tx_dev_sync_fifo.sv
// sync_fifo: small synchronous FIFO; a push is accepted when full if a pop happens on the same edge
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bridge-attached 8N1 UART transmitter with TX FIFO, programmable divisor and TX-empty irq
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DIV_RESET  = 32'd433
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [DEV_ADDR_WD-1:0] add_i,
    input  logic [31:0]            dat_i,
    output logic [31:0]            dat_o,
    output logic                   txd,
    output logic                   irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    utx_state_e  state_q, state_d;
    logic [15:0] baud_q, baud_d, reload_q, reload_d, div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d, head;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        txd_q, txd_d, ovf_q, ovf_d;
    logic        pop, push, full, empty, tick, start, busy;
    logic [CW-1:0] count;
    logic [1:0]  sel;
    logic        unused_bits;

    assign sel         = add_i[3:2];
    assign unused_bits = ^{add_i[DEV_ADDR_WD-1:4], add_i[1:0], dat_i[31:16], DIV_RESET[31:16]};
    assign push        = we_i & (sel == UART_REG_DATA);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .din_i(dat_i[7:0]),
        .dout_o(head), .full_o(full), .empty_o(empty), .count_o(count)
    );

    assign busy  = state_q != UTX_IDLE;
    assign tick  = baud_q == '0;
    // A frame launches from IDLE at once, or from STOP at its last cycle for back-to-back frames
    assign start = ctrl_q[CTRL_EN] & ~empty & (state_q == UTX_IDLE | (state_q == UTX_STOP & tick));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        reload_d = reload_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        if (start) begin
            pop      = 1'b1;
            shift_d  = head;
            reload_d = div_q;
            baud_d   = div_q;
            txd_d    = 1'b0;
            state_d  = UTX_START;
        end else if (busy) begin
            if (!tick) begin
                baud_d = baud_q - 16'd1;
            end else begin
                baud_d = reload_q;
                case (state_q)
                    UTX_START: begin
                        state_d = UTX_DATA;
                        txd_d   = shift_q[0];
                        bit_d   = '0;
                    end
                    UTX_DATA: begin
                        state_d = bit_q == 3'd7 ? UTX_STOP : UTX_DATA;
                        txd_d   = bit_q == 3'd7 ? 1'b1 : shift_q[1];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                    default: begin
                        state_d = UTX_IDLE;
                        txd_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ctrl_d = we_i & (sel == UART_REG_CTRL) ? dat_i[1:0] : ctrl_q;
        div_d  = we_i & (sel == UART_REG_DIV) ? dat_i[15:0] : div_q;
        ovf_d  = push & full & ~pop ? 1'b1 :
                 we_i & (sel == UART_REG_STATUS) & dat_i[ST_OVF_CLR] ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UTX_IDLE;
            baud_q   <= '0;
            reload_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ctrl_q   <= '0;
            div_q    <= DIV_RESET[15:0];
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            reload_q <= reload_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
        end
    end

    assign txd   = txd_q;
    assign irq   = ctrl_q[CTRL_IE] & empty & ~busy;
    assign dat_o = sel == UART_REG_CTRL ? {30'd0, ctrl_q} :
                   sel == UART_REG_DIV  ? {16'd0, div_q} :
                   sel == UART_REG_STATUS ? {25'd0, 3'(count), ovf_q, full, empty, busy} : 32'd0;
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed stimulus; a txd monitor decodes frames and checks them against a queue of expected frames
module tb_uart_tx_dev;
    logic        clk = 1'b0, reset = 1'b1, we = 1'b0;
    logic [7:0]  add = '0;
    logic [31:0] dat = '0, dat_o;
    logic        txd, irq;
    int          ncmp = 0, nfail = 0, cyc = 0;
    bit          mon_en = 1'b1;

    typedef struct {logic [7:0] b; int bt; bit contig;} frame_t;
    frame_t exp_q[$];

    uart_tx_dev dut (.clk(clk), .reset(reset), .we_i(we), .add_i(add), .dat_i(dat),
                     .dat_o(dat_o), .txd(txd), .irq(irq));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; add = {4'h0, s, 2'b00}; dat = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, output logic [31:0] v);
        add = {4'h0, s, 2'b00};
        #1 v = dat_o;
    endtask

    task automatic rdchk(input string name, input logic [1:0] s, input logic [31:0] exp);
        logic [31:0] v;
        rd(s, v);
        chk(name, v, exp);
    endtask

    task automatic expect_frame(input logic [7:0] b, input int bt, input bit contig);
        frame_t f;
        f.b = b; f.bt = bt; f.contig = contig;
        exp_q.push_back(f);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            rd(2'd3, v);
            n++;
        end while ((v[1:0] != 2'b10) && n < 3000);
        if (n >= 3000) begin
            ncmp++; nfail++;
            $display("FAIL idle_timeout: status 0x%0h still busy after %0d cycles", v, n);
        end
        repeat (3) @(posedge clk);
    endtask

    // Monitor: each detected start bit consumes one expected frame and checks every cycle of it
    initial begin
        frame_t f;
        logic [9:0] pat, got;
        bit bad;
        int st, last;
        last = -100;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && txd === 1'b0) begin
                st = cyc;
                if (exp_q.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with no frame expected", st);
                    while (txd === 1'b0) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    pat = {1'b1, f.b, 1'b0};
                    got = '0;
                    bad = 1'b0;
                    for (int i = 0; i < 10; i++)
                        for (int j = 0; j < f.bt; j++) begin
                            if (i != 0 || j != 0) @(negedge clk);
                            if (j == 0) got[i] = txd;
                            if (txd !== pat[i]) bad = 1'b1;
                        end
                    ncmp++;
                    if (bad || (f.contig && st != last + 1)) begin
                        nfail++;
                        $display("FAIL frame_%02h: got bits 0x%03h timing_err=%0b start=%0d prev_end=%0d, expected bits 0x%03h at %0d clk/bit contig=%0b",
                                 f.b, got, bad, st, last, pat, f.bt, f.contig);
                    end
                    last = cyc;
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        bit restarted;
        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        rdchk("reset_ctrl", 2'd1, 32'd0);
        rdchk("reset_div", 2'd2, 32'd433);
        rdchk("reset_status", 2'd3, 32'h2);
        rdchk("reset_data_read", 2'd0, 32'd0);
        chk("reset_txd_after", {31'd0, txd}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // 2: DIV=3, one frame of 0x55, busy exactly 40 clk
        wr(2'd2, 32'hFFFF_0003);
        rdchk("div_upper_ignored", 2'd2, 32'd3);
        wr(2'd1, 32'd1);
        expect_frame(8'h55, 4, 1'b0);
        wr(2'd0, 32'h55);
        rdchk("t2_status_queued", 2'd3, 32'h10);
        @(posedge clk); #1;
        rdchk("t2_status_busy_first", 2'd3, 32'h3);
        repeat (39) @(posedge clk);
        #1;
        rdchk("t2_status_busy_last", 2'd3, 32'h3);
        @(posedge clk); #1;
        rdchk("t2_status_idle", 2'd3, 32'h2);
        wait_idle();

        // 3: DIV=0, six back-to-back writes; first pops at once, sixth sees full
        wr(2'd2, 32'd0);
        expect_frame(8'h11, 1, 1'b0);
        expect_frame(8'h22, 1, 1'b1);
        expect_frame(8'h33, 1, 1'b1);
        expect_frame(8'h44, 1, 1'b1);
        expect_frame(8'h55, 1, 1'b1);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        wr(2'd0, 32'h44);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'h66);
        rdchk("t3_status_full_ovf", 2'd3, 32'h4D);
        wr(2'd3, 32'h8);
        rdchk("t3_status_ovf_cleared", 2'd3, 32'h45);
        wait_idle();

        // 4: TX-empty interrupt
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd3);
        chk("t4_irq_idle_empty", {31'd0, irq}, 32'd1);
        expect_frame(8'hA3, 4, 1'b0);
        wr(2'd0, 32'hA3);
        chk("t4_irq_after_write", {31'd0, irq}, 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("t4_irq_mid_frame", {31'd0, irq}, 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("t4_irq_last_stop_cycle", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("t4_irq_after_stop", {31'd0, irq}, 32'd1);
        expect_frame(8'h5A, 4, 1'b0);
        wr(2'd0, 32'h5A);
        chk("t4_irq_cleared_by_write", {31'd0, irq}, 32'd0);
        wait_idle();
        wr(2'd1, 32'd1);

        // 5: DIV change mid-frame applies only to the next frame
        wr(2'd2, 32'd7);
        expect_frame(8'hC4, 8, 1'b0);
        expect_frame(8'h3B, 2, 1'b1);
        wr(2'd0, 32'hC4);
        repeat (12) @(posedge clk);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h3B);
        wait_idle();

        // 6: reset mid-frame at data bit3
        mon_en = 1'b0;
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'h00);
        wr(2'd1, 32'd1);
        repeat (18) @(posedge clk);
        #1 chk("t6_txd_in_bit3", {31'd0, txd}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_txd_on_reset", {31'd0, txd}, 32'd1);
        rdchk("t6_status_reset", 2'd3, 32'h2);
        reset = 1'b0;
        wr(2'd1, 32'd1);
        restarted = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) restarted = 1'b1;
        end
        chk("t6_no_restart", {31'd0, restarted}, 32'd0);
        mon_en = 1'b1;

        chk("frames_outstanding", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
